// File: rtl/uart_cmd_parser_if.sv
// Byte-in / word-out bundle between the UART receiver, the command parser and the ALU core.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] word;
  logic [7:0]  opcode;
  logic        first;
  logic        last;
  logic        valid;
  logic        ready;
  logic        err;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_valid, ready,
    input  word, opcode, first, last, valid, err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid, ready,
    output word, opcode, first, last, valid, err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream into ALU command packets and emits little-endian 32-bit operand
// words with a one-word output buffer; reports opcode, length, timeout and overflow errors.
//
// state   | meaning
// IDLE    | waiting for opcode byte
// RSV     | expecting reserved header byte
// LEN_LO  | expecting length low byte
// LEN_HI  | expecting length high byte, length checked here
// PAYLOAD | assembling operand words
// DISCARD | dropping the rest of an aborted packet
module uart_cmd_parser #(
  parameter logic [15:0] MAX_LEN        = 16'd256,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input logic              clk_i,
  input logic              rst_ni,
  uart_cmd_parser_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RSV     = 3'd1;
  localparam logic [2:0] LEN_LO  = 3'd2;
  localparam logic [2:0] LEN_HI  = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] DISCARD = 3'd5;

  localparam logic [2:0] ERR_OPC = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_TMO = 3'd3;
  localparam logic [2:0] ERR_OVF = 3'd4;

  logic [2:0]  state;
  logic [7:0]  cur_opc;
  logic [7:0]  len_lo;
  logic [15:0] plen;
  logic [15:0] byte_cnt;
  logic [23:0] acc;
  logic [31:0] tmo_cnt;
  logic        pkt_err;

  logic [31:0] word;
  logic [7:0]  opcode;
  logic        first;
  logic        last;
  logic        valid;
  logic        err;
  logic [2:0]  err_code;

  logic [15:0] len_full;
  logic [15:0] byte_nxt;
  logic        len_bad;
  logic        len_short;
  logic        opc_ok;
  logic        tmo_hit;
  logic        last_byte;
  logic        out_blocked;

  assign len_full    = {bus.rx_data, len_lo};
  assign len_bad     = (len_full < 16'd8) || (len_full > MAX_LEN) || (len_full[1:0] != 2'b00);
  assign len_short   = (len_full <= 16'd4);
  assign byte_nxt    = byte_cnt + 16'd1;
  assign last_byte   = (byte_nxt == plen);
  assign opc_ok      = (bus.rx_data == 8'hEC) || (bus.rx_data == 8'hA0) ||
                       (bus.rx_data == 8'hB0) || (bus.rx_data == 8'hC0);
  assign tmo_hit     = (state != IDLE) && (tmo_cnt == TIMEOUT_CYCLES);
  assign out_blocked = valid && !bus.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cur_opc  <= 8'h00;
      len_lo   <= 8'h00;
      plen     <= 16'h0000;
      byte_cnt <= 16'h0000;
      acc      <= 24'h000000;
      tmo_cnt  <= 32'h0;
      pkt_err  <= 1'b0;
      word     <= 32'h0;
      opcode   <= 8'h00;
      first    <= 1'b0;
      last     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else begin
      err <= 1'b0;
      if (valid && bus.ready) valid <= 1'b0;

      // Timeout beats a byte arriving in the same cycle; the byte is dropped.
      if (tmo_hit) begin
        state   <= IDLE;
        tmo_cnt <= 32'h0;
        if (!pkt_err) begin
          err      <= 1'b1;
          err_code <= ERR_TMO;
        end
      end else begin
        if (bus.rx_valid)
          tmo_cnt <= 32'h0;
        else if (state != IDLE && tmo_cnt != TIMEOUT_CYCLES)
          tmo_cnt <= tmo_cnt + 32'h1;

        if (bus.rx_valid) begin
          case (state)
            IDLE: begin
              cur_opc  <= bus.rx_data;
              byte_cnt <= 16'h0000;
              pkt_err  <= !opc_ok;
              state    <= RSV;
              if (!opc_ok) begin
                err      <= 1'b1;
                err_code <= ERR_OPC;
              end
            end
            RSV:    state <= LEN_LO;
            LEN_LO: begin
              len_lo <= bus.rx_data;
              state  <= LEN_HI;
            end
            LEN_HI: begin
              plen <= len_full - 16'd4;
              // A bad-opcode packet still walks the header so its length can be skipped.
              if (pkt_err) begin
                state <= len_short ? IDLE : DISCARD;
              end else if (len_bad) begin
                err      <= 1'b1;
                err_code <= ERR_LEN;
                pkt_err  <= 1'b1;
                state    <= len_short ? IDLE : DISCARD;
              end else begin
                state <= PAYLOAD;
              end
            end
            PAYLOAD: begin
              byte_cnt <= byte_nxt;
              case (byte_cnt[1:0])
                2'd0: acc[7:0]   <= bus.rx_data;
                2'd1: acc[15:8]  <= bus.rx_data;
                2'd2: acc[23:16] <= bus.rx_data;
                default: begin
                  if (out_blocked) begin
                    err      <= 1'b1;
                    err_code <= ERR_OVF;
                    pkt_err  <= 1'b1;
                    state    <= last_byte ? IDLE : DISCARD;
                  end else begin
                    word   <= {bus.rx_data, acc};
                    opcode <= cur_opc;
                    first  <= (byte_cnt == 16'd3);
                    last   <= last_byte;
                    valid  <= 1'b1;
                    state  <= last_byte ? IDLE : PAYLOAD;
                  end
                end
              endcase
            end
            DISCARD: begin
              byte_cnt <= byte_nxt;
              if (byte_nxt >= plen) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.word     = word;
  assign bus.opcode   = opcode;
  assign bus.first    = first;
  assign bus.last     = last;
  assign bus.valid    = valid;
  assign bus.err      = err;
  assign bus.err_code = err_code;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: packets are modelled as they are sent, the monitor
// pops expected words/errors as the parser produces them.
module tb_uart_cmd_parser;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] w;
    logic [7:0]  op;
    logic        f;
    logic        l;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t       wq[$];
  logic [2:0] eq[$];
  exp_t       e;
  logic [2:0] ec;
  bq_t        p;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.MAX_LEN(16'd256), .TIMEOUT_CYCLES(32'd40)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid && bus.ready) begin
      if (wq.size() == 0) chk("extra_word", 32'(wq.size()), 32'd1);
      else begin
        e = wq.pop_front();
        chk("word", bus.word, e.w);
        chk("opcode", {24'h0, bus.opcode}, {24'h0, e.op});
        chk("first", {31'h0, bus.first}, {31'h0, e.f});
        chk("last", {31'h0, bus.last}, {31'h0, e.l});
      end
    end
    if (rst_n && bus.err) begin
      if (eq.size() == 0) chk("extra_err", 32'(eq.size()), 32'd1);
      else begin
        ec = eq.pop_front();
        chk("err_code", {29'h0, bus.err_code}, {29'h0, ec});
      end
    end
  end

  function automatic bq_t make_pkt(input logic [7:0] opc, input logic [15:0] len, input int n);
    bq_t q;
    q.push_back(opc);
    q.push_back(8'h00);
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference model for a packet sent with ready held high.
  task automatic expect_pkt(input bq_t q);
    logic [15:0] len;
    int          n;
    exp_t        x;
    len = {q[3], q[2]};
    if (!(q[0] inside {8'hEC, 8'hA0, 8'hB0, 8'hC0})) eq.push_back(3'd1);
    else if (len < 16'd8 || len > 16'd256 || (len % 16'd4) != 16'd0) eq.push_back(3'd2);
    else begin
      n = (int'(len) - 4) / 4;
      for (int i = 0; i < n; i++) begin
        x.w  = {q[4*i+7], q[4*i+6], q[4*i+5], q[4*i+4]};
        x.op = q[0];
        x.f  = (i == 0);
        x.l  = (i == n - 1);
        wq.push_back(x);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pkt(input bq_t q, input int maxgap);
    foreach (q[i]) send_byte(q[i], int'($urandom_range(0, maxgap)));
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(wq.size() + eq.size()), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, bus.valid}, 32'd0);
    chk("rst_err", {31'h0, bus.err}, 32'd0);
    chk("rst_code", {29'h0, bus.err_code}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_word", bus.word, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    expect_pkt(p);
    send_pkt(p, 0);
    drain("drain_add", 50);

    p = make_pkt(8'h55, 16'd8, 4);
    expect_pkt(p);
    send_pkt(p, 0);
    chk("opc_busy", {31'h0, bus.busy}, 32'd0);
    drain("drain_opc", 50);

    p = make_pkt(8'hA0, 16'd9, 5);
    expect_pkt(p);
    send_pkt(p, 0);
    chk("len9_busy", {31'h0, bus.busy}, 32'd0);
    drain("drain_len9", 50);
    p = make_pkt(8'hB0, 16'd16, 12);
    expect_pkt(p);
    send_pkt(p, 2);
    drain("drain_mul", 50);

    p = make_pkt(8'hA0, 16'd4, 0);
    expect_pkt(p);
    send_pkt(p, 0);
    chk("len4_busy", {31'h0, bus.busy}, 32'd0);
    drain("drain_len4", 50);

    p = make_pkt(8'hC0, 16'd256, 252);
    expect_pkt(p);
    send_pkt(p, 0);
    drain("drain_max", 50);
    p = make_pkt(8'hB0, 16'd260, 256);
    expect_pkt(p);
    send_pkt(p, 0);
    chk("len260_busy", {31'h0, bus.busy}, 32'd0);
    drain("drain_260", 50);

    // Overflow: first word parked with ready low, second completion must be dropped.
    bus.ready = 1'b0;
    p = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wq.push_back('{w: 32'h44332211, op: 8'hEC, f: 1'b1, l: 1'b0});
    eq.push_back(3'd4);
    send_pkt(p, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("ovf_held", bus.word, 32'h44332211);
    bus.ready = 1'b1;
    drain("drain_ovf", 50);

    // Word completes in the same cycle the held word is accepted: no overflow.
    bus.ready = 1'b0;
    p = make_pkt(8'hEC, 16'd12, 8);
    expect_pkt(p);
    for (int i = 0; i < 11; i++) send_byte(p[i], 0);
    bus.rx_data  = p[11];
    bus.rx_valid = 1'b1;
    bus.ready    = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    drain("drain_same", 50);

    p = make_pkt(8'hA0, 16'd12, 2);
    eq.push_back(3'd3);
    send_pkt(p, 0);
    drain("drain_tmo", 200);
    chk("tmo_busy", {31'h0, bus.busy}, 32'd0);
    p = make_pkt(8'hA0, 16'd12, 8);
    expect_pkt(p);
    send_pkt(p, 1);
    drain("drain_post_tmo", 50);

    // Reset with a word parked and a second word half built.
    bus.ready = 1'b0;
    p = make_pkt(8'hB0, 16'd16, 6);
    send_pkt(p, 0);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'h0, bus.valid}, 32'd1);
    chk("pre_rst_busy", {31'h0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, bus.valid}, 32'd0);
    chk("mid_rst_word", bus.word, 32'd0);
    chk("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("mid_rst_code", {29'h0, bus.err_code}, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    p = make_pkt(8'hC0, 16'd12, 8);
    expect_pkt(p);
    send_pkt(p, 0);
    drain("drain_post_rst", 50);

    chk("left_words", 32'(wq.size()), 32'd0);
    chk("left_errs", 32'(eq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
